// File: rtl/prog_loader.sv
// Program-image loader: writes a streamed byte image into a 2**AWIDTH x DWIDTH program memory and zero-fills the unused tail.
// Latency: a byte accepted at cycle N is written at N+1, and the loader is ready again at N+2. A CLEAR pass then writes one location per cycle.
// Backpressure: valid/ready. in_ready is high only in LOAD, so the loader accepts at most one byte per 2 cycles and never after the image ends.
//
// Ports: clk/rst (sync, active-high); in_valid/in_data/in_last/in_ready byte stream;
//        mem_addr/mem_data/mem_wr memory write port; cpu_rst/cpu_halt/done/restart CPU control;
//        ovf sticky overflow flag; chksum image checksum.
// Optional: define LOADER_CHKSUM_EN to enable the mod-2^DWIDTH byte-sum checksum (otherwise chksum is 0).
module prog_loader #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 2**AWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              restart,
    input  logic              cpu_halt,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_data,
    output logic              mem_wr,
    output logic              cpu_rst,
    output logic              done,
    output logic              ovf,
    output logic [DWIDTH-1:0] chksum
);

    typedef enum logic [2:0] {
        S_LOAD,
        S_WRITE,
        S_CLEAR,
        S_RUN,
        S_HALTED
    } state_t;

    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

    state_t            state_q;
    logic [AWIDTH-1:0] wptr_q;
    logic              last_q;      // byte now being written ends the image
    logic [AWIDTH-1:0] mem_addr_q;
    logic [DWIDTH-1:0] mem_data_q;
    logic              mem_wr_q;
    logic              cpu_rst_q;
    logic              done_q;
    logic              ovf_q;
    logic              accept;

    // Ready is decoded from state but forced low while reset is asserted.
    assign in_ready = (state_q == S_LOAD) && !rst;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_LOAD;
            wptr_q     <= '0;
            last_q     <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_wr_q   <= 1'b0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (accept) begin
                        mem_addr_q <= wptr_q;
                        mem_data_q <= in_data;
                        mem_wr_q   <= 1'b1;
                        // The final location always ends the image; without in_last it is an overflow.
                        last_q     <= in_last || (wptr_q == LAST_ADDR);
                        if ((wptr_q == LAST_ADDR) && !in_last) begin
                            ovf_q <= 1'b1;
                        end
                        state_q    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (wptr_q == LAST_ADDR) begin
                        // Memory is full: nothing left to clear.
                        mem_wr_q  <= 1'b0;
                        cpu_rst_q <= 1'b0;
                        state_q   <= S_RUN;
                    end else if (last_q) begin
                        wptr_q     <= wptr_q + 1'b1;
                        mem_addr_q <= wptr_q + 1'b1;
                        mem_data_q <= '0;
                        mem_wr_q   <= 1'b1;
                        state_q    <= S_CLEAR;
                    end else begin
                        wptr_q   <= wptr_q + 1'b1;
                        mem_wr_q <= 1'b0;
                        state_q  <= S_LOAD;
                    end
                end
                S_CLEAR: begin
                    if (mem_addr_q == LAST_ADDR) begin
                        mem_wr_q  <= 1'b0;
                        cpu_rst_q <= 1'b0;
                        state_q   <= S_RUN;
                    end else begin
                        mem_addr_q <= mem_addr_q + 1'b1;
                        wptr_q     <= wptr_q + 1'b1;
                    end
                end
                S_RUN: begin
                    if (cpu_halt) begin
                        done_q  <= 1'b1;
                        state_q <= S_HALTED;
                    end
                end
                S_HALTED: begin
                    if (restart) begin
                        wptr_q    <= '0;
                        cpu_rst_q <= 1'b1;
                        done_q    <= 1'b0;
                        ovf_q     <= 1'b0;
                        state_q   <= S_LOAD;
                    end
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign mem_wr   = mem_wr_q;
    assign cpu_rst  = cpu_rst_q;
    assign done     = done_q;
    assign ovf      = ovf_q;

`ifdef LOADER_CHKSUM_EN
    logic [DWIDTH-1:0] chksum_q;
    logic [DWIDTH-1:0] chksum_d;

    // Only accepted stream bytes contribute; the zero-fill never does.
    always_comb begin
        chksum_d = chksum_q;
        if (accept) begin
            chksum_d = chksum_q + in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chksum_q <= '0;
        end else if ((state_q == S_HALTED) && restart) begin
            chksum_q <= '0;
        end else begin
            chksum_q <= chksum_d;
        end
    end

    assign chksum = chksum_q;
`else
    assign chksum = '0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: cycle vector table for the first load, then directed sequences.
// Latency: checks sample outputs on the falling edge, half a cycle after each update.
// Backpressure: byte sends wait on in_ready with a bounded cycle budget.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic       restart;
    logic       cpu_halt;
    logic [4:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_wr;
    logic       cpu_rst;
    logic       done;
    logic       ovf;
    logic [7:0] chksum;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    logic [7:0] model [32];

    prog_loader dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready),
        .restart  (restart),
        .cpu_halt (cpu_halt),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_wr   (mem_wr),
        .cpu_rst  (cpu_rst),
        .done     (done),
        .ovf      (ovf),
        .chksum   (chksum)
    );

    always #5 clk = ~clk;

    // Memory model: records every write the loader issues.
    always @(negedge clk) begin
        if (mem_wr === 1'b1) begin
            model[mem_addr] = mem_data;
            wr_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rst;
        logic       vld;
        logic       lst;
        logic [7:0] dat;
        logic       e_rdy;
        logic       e_wr;
        logic       e_crst;
        logic [4:0] e_addr;
        logic [7:0] e_dat;
    } vec_t;

    vec_t vt [8];

    function automatic vec_t mk(input logic r, input logic v, input logic l, input logic [7:0] d,
                                input logic er, input logic ew, input logic ec,
                                input logic [4:0] ea, input logic [7:0] ed);
        vec_t x;
        x.rst = r; x.vld = v; x.lst = l; x.dat = d;
        x.e_rdy = er; x.e_wr = ew; x.e_crst = ec; x.e_addr = ea; x.e_dat = ed;
        return x;
    endfunction

    function automatic logic [7:0] exp_ck(input logic [7:0] sum);
`ifdef LOADER_CHKSUM_EN
        return sum;
`else
        return (sum & 8'h00);
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Offer one byte until accepted; on return the write cycle is visible.
    task automatic send(input logic [7:0] d, input logic l, input logic [4:0] ea);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready_timeout", 32'(n < 20), 32'h1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("send_wr", 32'(mem_wr), 32'h1);
        chk("send_addr", 32'(mem_addr), 32'(ea));
        chk("send_data", 32'(mem_data), 32'(d));
        chk("send_rdy_low", 32'(in_ready), 32'h0);
    endtask

    task automatic wait_run();
        int n = 0;
        while (cpu_rst !== 1'b0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("run_timeout", 32'(n < 64), 32'h1);
    endtask

    // From RUN: halt the CPU, check done, then restart the loader.
    task automatic halt_restart();
        @(negedge clk);
        cpu_halt = 1'b1;
        @(negedge clk);
        cpu_halt = 1'b0;
        chk("halt_done", 32'(done), 32'h1);
        chk("halt_crst", 32'(cpu_rst), 32'h0);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("rs_crst", 32'(cpu_rst), 32'h1);
        chk("rs_done", 32'(done), 32'h0);
        chk("rs_rdy", 32'(in_ready), 32'h1);
        chk("rs_ovf", 32'(ovf), 32'h0);
        chk("rs_chksum", 32'(chksum), 32'h0);
    endtask

    initial begin
        logic [7:0] sum;
        int rdy_seen;

        for (int i = 0; i < 32; i++) model[i] = 8'h55;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
        restart = 1'b0; cpu_halt = 1'b0;

        //            rst vld lst dat     rdy wr crst addr dat
        vt[0] = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 8'h00);
        vt[1] = mk(1'b0, 1'b1, 1'b0, 8'hA3, 1'b0, 1'b1, 1'b1, 5'd0, 8'hA3);
        vt[2] = mk(1'b0, 1'b1, 1'b0, 8'h1F, 1'b1, 1'b0, 1'b1, 5'd0, 8'hA3);
        vt[3] = mk(1'b0, 1'b1, 1'b0, 8'h1F, 1'b0, 1'b1, 1'b1, 5'd1, 8'h1F);
        vt[4] = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 5'd1, 8'h1F);
        vt[5] = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 5'd1, 8'h1F);
        vt[6] = mk(1'b0, 1'b1, 1'b1, 8'hE5, 1'b0, 1'b1, 1'b1, 5'd2, 8'hE5);
        vt[7] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 5'd3, 8'h00);

        // Load A3, 1F, E5 (last), then follow the CLEAR pass.
        for (int i = 0; i < 8; i++) begin
            rst = vt[i].rst; in_valid = vt[i].vld; in_last = vt[i].lst; in_data = vt[i].dat;
            @(negedge clk);
            chk($sformatf("v%0d_rdy", i), 32'(in_ready), 32'(vt[i].e_rdy));
            chk($sformatf("v%0d_wr", i), 32'(mem_wr), 32'(vt[i].e_wr));
            chk($sformatf("v%0d_crst", i), 32'(cpu_rst), 32'(vt[i].e_crst));
            chk($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(vt[i].e_addr));
            chk($sformatf("v%0d_data", i), 32'(mem_data), 32'(vt[i].e_dat));
            chk($sformatf("v%0d_done", i), 32'(done), 32'h0);
            chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'h0);
            if (i == 0) chk("reset_chksum", 32'(chksum), 32'h0);
        end
        for (int a = 4; a < 32; a++) begin
            @(negedge clk);
            chk($sformatf("clr%0d_wr", a), 32'(mem_wr), 32'h1);
            chk($sformatf("clr%0d_addr", a), 32'(mem_addr), 32'(a));
            chk($sformatf("clr%0d_data", a), 32'(mem_data), 32'h0);
            chk($sformatf("clr%0d_crst", a), 32'(cpu_rst), 32'h1);
        end
        @(negedge clk);
        chk("t1_run_wr", 32'(mem_wr), 32'h0);
        chk("t1_run_crst", 32'(cpu_rst), 32'h0);
        chk("t1_chksum", 32'(chksum), 32'(exp_ck(8'hA7)));
        #1;
        chk("t1_wr_cnt", 32'(wr_cnt), 32'd32);
        chk("t1_m0", 32'(model[0]), 32'hA3);
        chk("t1_m1", 32'(model[1]), 32'h1F);
        chk("t1_m2", 32'(model[2]), 32'hE5);
        chk("t1_m3", 32'(model[3]), 32'h00);
        chk("t1_m31", 32'(model[31]), 32'h00);

        // RUN ignores the stream and restart; then halt, restart and load a 2-byte image with a long gap.
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h99; in_last = 1'b1; restart = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; restart = 1'b0;
        chk("run_rdy", 32'(in_ready), 32'h0);
        chk("run_wr", 32'(mem_wr), 32'h0);
        chk("run_restart_ignored", 32'(cpu_rst), 32'h0);
        chk("run_done", 32'(done), 32'h0);
        halt_restart();
        wr_cnt = 0;
        send(8'h5A, 1'b0, 5'd0);
        in_last = 1'b1;
        repeat (6) @(negedge clk);
        chk("gap_no_wr", 32'(mem_wr), 32'h0);
        chk("gap_rdy", 32'(in_ready), 32'h1);
        #1;
        chk("gap_wr_cnt", 32'(wr_cnt), 32'd1);
        in_last = 1'b0;
        send(8'hC3, 1'b1, 5'd1);
        wait_run();
        #1;
        chk("t2_wr_cnt", 32'(wr_cnt), 32'd32);
        chk("t2_m0", 32'(model[0]), 32'h5A);
        chk("t2_m1", 32'(model[1]), 32'hC3);
        chk("t2_m2", 32'(model[2]), 32'h00);
        chk("t2_chksum", 32'(chksum), 32'(exp_ck(8'h1D)));

        // Full 32-byte image: RUN directly, no CLEAR.
        halt_restart();
        wr_cnt = 0;
        for (int i = 0; i < 32; i++) send(8'(i), (i == 31), 5'(i));
        @(negedge clk);
        chk("full_crst", 32'(cpu_rst), 32'h0);
        chk("full_wr", 32'(mem_wr), 32'h0);
        chk("full_ovf", 32'(ovf), 32'h0);
        #1;
        chk("full_wr_cnt", 32'(wr_cnt), 32'd32);
        chk("full_m31", 32'(model[31]), 32'h1F);
        chk("full_m5", 32'(model[5]), 32'h05);
        chk("full_chksum", 32'(chksum), 32'(exp_ck(8'hF0)));

        // Overflow: 32 bytes without in_last, then a 33rd that must never be taken.
        halt_restart();
        wr_cnt = 0;
        for (int i = 0; i < 32; i++) send(8'(8'h80 + i), 1'b0, 5'(i));
        chk("ovf_set", 32'(ovf), 32'h1);
        in_valid = 1'b1; in_data = 8'hEE;
        rdy_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (in_ready !== 1'b0) rdy_seen++;
        end
        in_valid = 1'b0;
        chk("ovf_rdy_stays_low", 32'(rdy_seen), 32'd0);
        chk("ovf_crst", 32'(cpu_rst), 32'h0);
        chk("ovf_sticky", 32'(ovf), 32'h1);
        #1;
        chk("ovf_wr_cnt", 32'(wr_cnt), 32'd32);
        chk("ovf_m31", 32'(model[31]), 32'h9F);

        // Reset after 5 bytes; the next byte lands at address 0.
        halt_restart();
        sum = 8'h00;
        for (int i = 0; i < 5; i++) begin
            send(8'(8'h11 + i), 1'b0, 5'(i));
            sum = sum + 8'(8'h11 + i);
        end
        chk("pre_rst_chksum", 32'(chksum), 32'(exp_ck(sum)));
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_rdy", 32'(in_ready), 32'h0);
        chk("mrst_addr", 32'(mem_addr), 32'h0);
        chk("mrst_data", 32'(mem_data), 32'h0);
        chk("mrst_wr", 32'(mem_wr), 32'h0);
        chk("mrst_crst", 32'(cpu_rst), 32'h1);
        chk("mrst_done", 32'(done), 32'h0);
        chk("mrst_ovf", 32'(ovf), 32'h0);
        chk("mrst_chksum", 32'(chksum), 32'h0);
        rst = 1'b0;
        send(8'h77, 1'b1, 5'd0);
        wait_run();
        #1;
        chk("mrst_m0", 32'(model[0]), 32'h77);
        chk("mrst_m1", 32'(model[1]), 32'h00);
        chk("mrst_m4", 32'(model[4]), 32'h00);
        chk("mrst_final_chksum", 32'(chksum), 32'(exp_ck(8'h77)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
